mem_access_unit: RTL

Load/store initiator that sits between the CPU execute stage and the 8-bit, 256-entry synchronous data memory. It accepts byte and halfword load/store requests over a valid/ready handshake and sequences them into single-byte `mem_read`/`mem_write` cycles. It assembles halfword and sign- or zero-extended byte load results, and returns a one-cycle response pulse. Halfwords are little-endian: the low byte is at `addr` and the high byte at `addr+1` mod 256.

---
 rtl/mem_access_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator: splits byte/halfword requests into single-byte
// accesses on an 8-bit synchronous data memory and returns a one-cycle response.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_half,
  input  logic        req_signed,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [7:0]  mem_address,
  output logic [7:0]  mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        half_q, half_d;
  logic        signed_q, signed_d;
  logic [7:0]  lo_q, lo_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_rdata_q, resp_rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      half_q       <= 1'b0;
      signed_q     <= 1'b0;
      lo_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      half_q       <= half_d;
      signed_q     <= signed_d;
      lo_q         <= lo_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    half_d       = half_q;
    signed_d     = signed_q;
    lo_d         = lo_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          write_d  = req_write;
          half_d   = req_half;
          signed_d = req_signed;
          state_d  = ACC0;
        end
      end
      ACC0: begin
        if (half_q) begin
          state_d = ACC1;
        end else if (write_q) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          state_d = FIN;
        end
      end
      ACC1: begin
        if (write_q) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          // Read data for the ACC0 strobe arrives during this cycle.
          lo_d    = mem_read_data;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        if (half_q)
          resp_rdata_d = {mem_read_data, lo_q};
        else
          resp_rdata_d = {{8{signed_q & mem_read_data[7]}}, mem_read_data};
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_address    = addr_q;
    mem_write_data = wdata_q[7:0];
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    unique case (state_q)
      ACC0: begin
        mem_read  = ~write_q;
        mem_write = write_q;
      end
      ACC1: begin
        mem_address    = addr_q + 8'd1;
        mem_write_data = wdata_q[15:8];
        mem_read       = ~write_q;
        mem_write      = write_q;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule
